// File: rtl/leg_alu_pkg.sv
// Shared types and constants for the LEG ALU datapath blocks.
package leg_alu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    // Never returns 0, so a counter declared with it always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module _div_step
    import leg_alu_pkg::*;
#(
    parameter int unsigned UUID  = 0,
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] R,
    input  logic             Qmsb,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;

    // t needs WIDTH+1 bits because R may already have its msb set; t < 2*D so t-D fits WIDTH.
    always_comb begin
        t      = {R, Qmsb};
        q_bit  = (t >= {1'b0, D});
        R_next = q_bit ? WIDTH'(t - {1'b0, D}) : t[WIDTH-1:0];
    end

endmodule

// File: rtl/_8b_seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, results held between ops.
module _8b_seq_divider
    import leg_alu_pkg::*;
#(
    parameter int unsigned UUID  = 0,
    parameter string       NAME  = "",
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Input_1,
    input  logic [WIDTH-1:0] Input_2,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int unsigned CntW = clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;

    _div_step #(
        .UUID  (UUID ^ 32'h1),
        .WIDTH (WIDTH)
    ) u_step (
        .R      (r_q),
        .Qmsb   (q_q[WIDTH-1]),
        .D      (d_q),
        .R_next (r_next),
        .q_bit  (q_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    if (Input_2 != '0) begin
                        state_d = RUN;
                        q_d     = Input_1;
                        d_d     = Input_2;
                        r_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        // Divide by zero resolves immediately without iterating.
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = Input_1;
                        dbz_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                q_d   = {q_q[WIDTH-2:0], q_bit};
                r_d   = r_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quot_d  = {q_q[WIDTH-2:0], q_bit};
                    rem_d   = r_next;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign Quotient    = quot_q;
    assign Remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb__8b_seq_divider.sv
// Self-checking bench for _8b_seq_divider: directed corner cases plus random ops vs x/y, x%y.
module tb__8b_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] in1, in2, quo, rem;
    logic         busy, done, dbz;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    _8b_seq_divider #(
        .UUID  (0),
        .NAME  ("dut"),
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Input_1     (in1),
        .Input_2     (in2),
        .Quotient    (quo),
        .Remainder   (rem),
        .busy        (busy),
        .done        (done),
        .div_by_zero (dbz)
    );

    // Stimulus only: issue one op, then count edges after the accept edge until done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0; in1 = W'($urandom); in2 = W'($urandom);
        lat = 0; nbusy = 0;
        while (!done && lat <= W + 4) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat, nb;
        bit seen;
        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        #12;
        total++;
        if ({quo, rem, busy, done, dbz} !== '0)
            begin bad++; $display("FAIL reset_init: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0", quo, rem, busy, done, dbz); end
        @(negedge clk); rst = 1'b0;
        run_op(8'd100, 8'd7, lat, nb);
        total++;
        if (quo !== 8'd14)
            begin bad++; $display("FAIL reset_preload: got q=%0d want 14", quo); end
        @(negedge clk);
        start = 1'b1; in1 = 8'd100; in2 = 8'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #2; rst = 1'b1; #1;
        total++;
        if ({quo, rem, busy, done, dbz} !== '0)
            begin bad++; $display("FAIL reset_midrun: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0", quo, rem, busy, done, dbz); end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0)
            begin bad++; $display("FAIL reset_abort: got done/busy activity=%b want 0", seen); end
    endtask

    task automatic test_basic();
        int lat, nb;
        run_op(8'd100, 8'd7, lat, nb);
        total++;
        if (lat !== W) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
        total++;
        if (nb !== W) begin bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", nb, W); end
        total++;
        if ({quo, rem, dbz} !== {8'd14, 8'd2, 1'b0})
            begin bad++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b want q=14 r=2 dbz=0", quo, rem, dbz); end
    endtask

    task automatic test_corners();
        logic [W-1:0] ta [4] = '{8'd255, 8'd7,   8'd200, 8'd128};
        logic [W-1:0] tb [4] = '{8'd1,   8'd200, 8'd200, 8'd255};
        logic [W-1:0] eq [4] = '{8'd255, 8'd0,   8'd1,   8'd0};
        logic [W-1:0] er [4] = '{8'd0,   8'd7,   8'd0,   8'd128};
        int lat, nb;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], lat, nb);
            total++;
            if ({quo, rem, dbz} !== {eq[i], er[i], 1'b0})
                begin bad++; $display("FAIL corner_%0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0", ta[i], tb[i], quo, rem, dbz, eq[i], er[i]); end
        end
    endtask

    task automatic test_div_zero();
        int lat, nb;
        run_op(8'd57, 8'd0, lat, nb);
        // Zero divisor goes straight to DONE on the accept edge.
        total++;
        if (lat !== 0) begin bad++; $display("FAIL dbz_latency: got %0d want 0", lat); end
        total++;
        if (nb !== 0) begin bad++; $display("FAIL dbz_busy: got %0d busy cycles want 0", nb); end
        total++;
        if ({quo, rem, dbz} !== {8'd255, 8'd57, 1'b1})
            begin bad++; $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b want q=255 r=57 dbz=1", quo, rem, dbz); end
    endtask

    task automatic test_back_to_back();
        int lat, n;
        @(negedge clk);
        start = 1'b1; in1 = 8'd100; in2 = 8'd7;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        start = 1'b1; in1 = 8'd9; in2 = 8'd4;
        @(posedge clk); #1; start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin @(posedge clk); #1; lat++; end
        total++;
        if (lat !== W) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, W); end
        total++;
        if ({quo, rem} !== {8'd14, 8'd2})
            begin bad++; $display("FAIL ignore_result: got q=%0d r=%0d want q=14 r=2", quo, rem); end
        @(negedge clk);
        start = 1'b1; in1 = 8'd9; in2 = 8'd4;
        @(posedge clk); #1; start = 1'b0;
        n = 0;
        while (!done && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (n + 1 !== W + 1) begin bad++; $display("FAIL b2b_gap: got %0d cycles want %0d", n + 1, W + 1); end
        total++;
        if ({quo, rem} !== {8'd2, 8'd1})
            begin bad++; $display("FAIL b2b_result: got q=%0d r=%0d want q=2 r=1", quo, rem); end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er, pq, pr;
        logic         ed, pd;
        int           n, idle;
        pq = 8'd2; pr = 8'd1; pd = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            a    = W'($urandom);
            b    = (i % 16 == 0) ? '0 : W'($urandom);
            idle = $urandom_range(0, 3);
            repeat (idle) begin
                @(negedge clk);
                total++;
                if ({quo, rem, dbz} !== {pq, pr, pd})
                    begin bad++; $display("FAIL rand_hold_idle: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", quo, rem, dbz, pq, pr, pd); end
            end
            @(negedge clk);
            start = 1'b1; in1 = a; in2 = b;
            @(posedge clk); #1;
            start = 1'b0; in1 = W'($urandom); in2 = W'($urandom);
            n = 0;
            while (!done && n <= W + 4) begin
                total++;
                if ({quo, rem, dbz} !== {pq, pr, pd})
                    begin bad++; $display("FAIL rand_hold_run: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", quo, rem, dbz, pq, pr, pd); end
                @(posedge clk); #1;
                n++;
            end
            ed = (b == 0);
            eq = ed ? '1 : W'(int'(a) / int'(b));
            er = ed ? a  : W'(int'(a) % int'(b));
            total++;
            if (n !== (ed ? 0 : W))
                begin bad++; $display("FAIL rand_latency: %0d/%0d got %0d", a, b, n); end
            total++;
            if ({quo, rem, dbz} !== {eq, er, ed})
                begin bad++; $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b", a, b, quo, rem, dbz, eq, er, ed); end
            if (!ed) begin
                total++;
                if (int'(a) !== int'(quo) * int'(b) + int'(rem) || rem >= b)
                    begin bad++; $display("FAIL rand_invariant %0d/%0d: got q=%0d r=%0d", a, b, quo, rem); end
            end
            pq = eq; pr = er; pd = ed;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
